// File: rtl/cache_req_ctrl_if.sv
// Request/response handshake bundle between a cache client and cache_req_ctrl.
// The master modport is the client; the slave modport is the controller.
interface cache_req_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  ReqValid_SI;
  logic                  ReqReady_SO;
  logic                  ReqWrite_SI;
  logic [7:0]            ReqBEn_SI;
  logic [63:0]           ReqWData_DI;
  logic [ADDR_WIDTH-1:0] ReqAddr_DI;
  logic                  RspValid_SO;
  logic                  RspReady_SI;
  logic [63:0]           RspRData_DO;
  logic                  RspMismatch_SO;

  modport master (
    output ReqValid_SI, ReqWrite_SI, ReqBEn_SI, ReqWData_DI, ReqAddr_DI, RspReady_SI,
    input  ReqReady_SO, RspValid_SO, RspRData_DO, RspMismatch_SO
  );

  modport slave (
    input  ReqValid_SI, ReqWrite_SI, ReqBEn_SI, ReqWData_DI, ReqAddr_DI, RspReady_SI,
    output ReqReady_SO, RspValid_SO, RspRData_DO, RspMismatch_SO
  );
endinterface

// File: rtl/cache_req_ctrl.sv
// Single-outstanding initiator for a duplicated cache SRAM pair; compares both copies on
// every read and keeps a sticky first-mismatch record.
module cache_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  cache_req_ctrl_if.slave       bus,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [63:0]           WrData_DO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  input  logic [63:0]           RdData_DI_1,
  input  logic [63:0]           RdData_DI_2,
  output logic                  ErrSticky_SO,
  output logic [ADDR_WIDTH-1:0] ErrAddr_DO,
  input  logic                  ErrClr_SI
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [7:0]            ben_q, ben_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  mism_q, mism_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic capture;
  logic copies_differ;

  assign copies_differ = (RdData_DI_1 != RdData_DI_2);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= StIdle;
      cnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      ben_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      mism_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      ben_q      <= ben_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      mism_q     <= mism_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    ben_d      = ben_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    mism_d     = mism_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    capture    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.ReqValid_SI) begin
          wr_d    = bus.ReqWrite_SI;
          ben_d   = bus.ReqBEn_SI;
          wdata_d = bus.ReqWData_DI;
          addr_d  = bus.ReqAddr_DI;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (wr_q) begin
          rdata_d = '0;
          mism_d  = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d   = 1'(OUT_REGS);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 1'b0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          rdata_d = RdData_DI_1;
          mism_d  = copies_differ;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.RspReady_SI) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A mismatch capture beats a simultaneous clear and records the new address.
    if (capture && copies_differ && (!err_q || ErrClr_SI)) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
    end else if (ErrClr_SI) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  // SRAM pins are driven only during the single access cycle.
  always_comb begin
    CSel_SO            = 1'b0;
    WrEn_SO            = 1'b0;
    BEn_SO             = '0;
    WrData_DO          = '0;
    Addr_DO            = '0;
    bus.ReqReady_SO    = (state_q == StIdle);
    bus.RspValid_SO    = 1'b0;
    bus.RspRData_DO    = '0;
    bus.RspMismatch_SO = 1'b0;
    if (state_q == StIssue) begin
      CSel_SO = 1'b1;
      WrEn_SO = wr_q;
      Addr_DO = addr_q;
      if (wr_q) begin
        BEn_SO    = ben_q;
        WrData_DO = wdata_q;
      end
    end
    if (state_q == StResp) begin
      bus.RspValid_SO    = 1'b1;
      bus.RspRData_DO    = rdata_q;
      bus.RspMismatch_SO = mism_q;
    end
  end

  assign ErrSticky_SO = err_q;
  assign ErrAddr_DO   = err_addr_q;

endmodule

// File: doc/cache_req_ctrl.md
Name: cache_req_ctrl

Overview:
Initiator for the duplicated cache SRAM pair. Accepts single read/write requests over a valid/ready handshake and issues each one as a one-cycle SRAM access to both copies, which share all inputs. For reads, it waits the SRAM read latency, captures both copies' read data, compares them, and returns the data with a per-response mismatch flag. It also keeps a sticky error flag and records the address of the first mismatch, giving S²QED-style duplicate-consistency checking at the cache boundary.

Parameters:
ADDR_WIDTH, 8, SRAM word address width; must match the SRAM pair.
OUT_REGS, 0, 0 or 1; must match the SRAM pair. Read latency after the access cycle is 1+OUT_REGS cycles.

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
ReqValid_SI  in  1  request valid
ReqReady_SO  out  1  request ready
ReqWrite_SI  in  1  1=write, 0=read
ReqBEn_SI  in  8  write byte enables
ReqWData_DI  in  64  write data
ReqAddr_DI  in  ADDR_WIDTH  word address
RspValid_SO  out  1  response valid
RspReady_SI  in  1  response ready
RspRData_DO  out  64  read data from copy 1; 0 for writes
RspMismatch_SO  out  1  copies disagreed on this read
CSel_SO  out  1  SRAM chip select
WrEn_SO  out  1  SRAM write enable
BEn_SO  out  8  SRAM byte enables
WrData_DO  out  64  SRAM write data
Addr_DO  out  ADDR_WIDTH  SRAM address
RdData_DI_1  in  64  read data, copy 1
RdData_DI_2  in  64  read data, copy 2
ErrSticky_SO  out  1  a mismatch has occurred since reset/clear
ErrAddr_DO  out  ADDR_WIDTH  address of the first mismatch
ErrClr_SI  in  1  clears ErrSticky_SO and ErrAddr_DO

Behaviour:
- Reset (async, Rst_RBI=0): FSM goes to IDLE; every output is 0 except ReqReady_SO, which is 1 once in IDLE; the latency counter is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ReqReady_SO=1.
  - When ReqValid_SI=1, the request (write, BEn, data, addr) is registered and the FSM moves to ISSUE.
- ISSUE (exactly one cycle):
  - CSel_SO=1, WrEn_SO=write, Addr_DO=registered addr.
  - Writes: BEn_SO and WrData_DO take the registered values. Reads: BEn_SO=0 and WrData_DO=0.
  - Next state: writes go to RESP; reads go to WAIT with the counter loaded to OUT_REGS.
- WAIT:
  - While counter ≠ 0, decrement.
  - When counter = 0: capture RdData_DI_1 into RspRData_DO, set RspMismatch_SO = (RdData_DI_1 != RdData_DI_2), and go to RESP.
- RESP:
  - RspValid_SO=1. RspRData_DO and RspMismatch_SO stay stable until RspReady_SI=1.
  - Write responses have RspRData_DO=0 and RspMismatch_SO=0.
  - When RspReady_SI=1, go to IDLE.
- Outside ISSUE, all SRAM outputs are 0.
- Latency, counted from the accept edge at cycle t0:
  - Write: ISSUE at t0+1, RspValid_SO at t0+2.
  - Read: ISSUE at t0+1, capture at t0+2+OUT_REGS, RspValid_SO at t0+3+OUT_REGS.
- Only one request is outstanding at a time. ReqReady_SO=0 in every state except IDLE. A request cannot be accepted in the same cycle a response is consumed; the earliest next accept is the cycle after.
- Error tracking:
  - When a mismatch is captured and ErrSticky_SO=0, ErrSticky_SO goes to 1 and ErrAddr_DO takes the mismatching address.
  - Later mismatches do not change ErrAddr_DO.
  - ErrClr_SI=1 clears both outputs on the next edge.
  - If a mismatch capture and ErrClr_SI occur in the same cycle, the capture wins: the flag is set and the new address is recorded.
- A write with BEn=0 is still issued (CSel_SO=1, WrEn_SO=1, BEn_SO=0) and still acknowledged.
- Address 0 and address 2^ADDR_WIDTH−1 are handled identically to any other address; there is no wrap logic.
- Reset asserted mid-operation drops the pending request and any response. CSel_SO falls asynchronously, and there is no response after reset.

Test Plan:
1. Write addr 0x05, data 0x1122334455667788, BEn 0xFF, then read 0x05 with both copies returning the same data → one CSel pulse each; read response carries 0x1122334455667788 with mismatch=0; read RspValid_SO at t0+3 (OUT_REGS=0) and t0+4 (OUT_REGS=1).
2. Read addr 0xFF with RdData_DI_1=0xA, RdData_DI_2=0xB → RspRData_DO=0xA, RspMismatch_SO=1, ErrSticky_SO=1, ErrAddr_DO=0xFF. A second mismatch at 0x10 leaves ErrAddr_DO=0xFF.
3. Hold RspReady_SI=0 for 5 cycles → response stays stable, ReqReady_SO=0 throughout, no new CSel pulse even with ReqValid_SI=1; the request is accepted in the cycle after the response handshake.
4. Assert ErrClr_SI in the same cycle as a mismatch capture at 0x22 → ErrSticky_SO=1, ErrAddr_DO=0x22. ErrClr_SI alone afterwards → both outputs 0.
5. Write with BEn=0x00 → CSel_SO=1, WrEn_SO=1, BEn_SO=0 for one cycle; write ack with RspRData_DO=0 and RspMismatch_SO=0.
6. Drop Rst_RBI during WAIT → all outputs 0 immediately, no response after release, ReqReady_SO=1 in the first cycle after release.
